// File: rtl/ysyx_22050550_clint_arbiter_pkg.sv
// Shared CLINT arbiter definitions: register addresses, FSM states, requester indices, strobe helper.
// Optional round-robin arbitration is enabled by defining YSYX_22050550_CLINT_ARB_RR_EN.
`ifndef ysyx_22050550_MTIME
`define ysyx_22050550_MTIME 64'h0000_0000_0200_bff8
`endif
`ifndef ysyx_22050550_MTIMECMP
`define ysyx_22050550_MTIMECMP 64'h0000_0000_0200_4000
`endif

package ysyx_22050550_clint_arbiter_pkg;

    localparam logic [63:0] MtimeAddr    = `ysyx_22050550_MTIME;
    localparam logic [63:0] MtimecmpAddr = `ysyx_22050550_MTIMECMP;

    localparam int unsigned ReqLsu = 0;
    localparam int unsigned ReqDbg = 1;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StResp
    } state_e;

    function automatic logic [63:0] strb_to_mask(input logic [7:0] strb);
        logic [63:0] mask;
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            mask[i*8 +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/ysyx_22050550_clint_rmw_merge.sv
// Byte-strobe merge for partial CLINT stores: old bytes kept where the strobe is clear.
module ysyx_22050550_clint_rmw_merge
    import ysyx_22050550_clint_arbiter_pkg::*;
(
    input  logic [63:0] old_i,
    input  logic [63:0] wdata_i,
    input  logic [7:0]  wstrb_i,
    output logic [63:0] merged_o
);

    logic [63:0] mask;

    assign mask     = strb_to_mask(wstrb_i);
    assign merged_o = (old_i & ~mask) | (wdata_i & mask);

endmodule

// File: rtl/ysyx_22050550_clint_arbiter.sv
// Two-requester CLINT arbiter with single-cycle ren/wen port and read-modify-write for partial stores.
// Define YSYX_22050550_CLINT_ARB_RR_EN for round-robin grant; default is fixed priority to r0.
module ysyx_22050550_clint_arbiter
    import ysyx_22050550_clint_arbiter_pkg::*;
#(
    parameter int unsigned AW = 64,
    parameter int unsigned DW = 64
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [1:0]           req_valid_i,
    output logic [1:0]           req_ready_o,
    input  logic [1:0]           req_wen_i,
    input  logic [1:0][AW-1:0]   req_addr_i,
    input  logic [1:0][DW-1:0]   req_wdata_i,
    input  logic [1:0][DW/8-1:0] req_wstrb_i,
    output logic [1:0]           rsp_valid_o,
    input  logic [1:0]           rsp_ready_i,
    output logic [DW-1:0]        rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 clint_ren_o,
    output logic [63:0]          clint_raddr_o,
    output logic                 clint_wen_o,
    output logic [63:0]          clint_waddr_o,
    output logic [DW-1:0]        clint_wdata_o,
    input  logic [DW-1:0]        clint_rdata_i
);

    state_e            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              wen_q, wen_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW/8-1:0]   wstrb_q, wstrb_d;
    logic [DW-1:0]     data_q, data_d;
    logic              err_q, err_d;

    logic              gnt;
    logic              accept;
    logic              sel_hit;
    logic [AW-1:0]     sel_addr;
    logic [DW/8-1:0]   sel_strb;
    logic [DW-1:0]     merged;

`ifdef YSYX_22050550_CLINT_ARB_RR_EN
    logic last_q, last_d;

    // On a tie the requester that was not granted last time wins.
    assign gnt    = (&req_valid_i) ? ~last_q : ~req_valid_i[0];
    assign last_d = accept ? gnt : last_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            last_q <= 1'(ReqDbg);
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign gnt = ~req_valid_i[0];
`endif

    assign accept   = (state_q == StIdle) && (|req_valid_i);
    assign sel_addr = req_addr_i[gnt];
    assign sel_strb = req_wstrb_i[gnt];
    assign sel_hit  = ((sel_addr == AW'(MtimeAddr)) || (sel_addr == AW'(MtimecmpAddr)))
                      && (sel_addr[2:0] == 3'b000);

    ysyx_22050550_clint_rmw_merge u_merge (
        .old_i    (data_q),
        .wdata_i  (wdata_q),
        .wstrb_i  (wstrb_q),
        .merged_o (merged)
    );

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        wen_d         = wen_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        data_d        = data_q;
        err_d         = err_q;
        req_ready_o   = 2'b00;
        rsp_valid_o   = 2'b00;
        rsp_rdata_o   = '0;
        rsp_err_o     = 1'b0;
        clint_ren_o   = 1'b0;
        clint_raddr_o = '0;
        clint_wen_o   = 1'b0;
        clint_waddr_o = '0;
        clint_wdata_o = '0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    req_ready_o[gnt] = 1'b1;
                    gnt_d   = gnt;
                    wen_d   = req_wen_i[gnt];
                    addr_d  = sel_addr;
                    wdata_d = req_wdata_i[gnt];
                    wstrb_d = sel_strb;
                    data_d  = '0;
                    err_d   = 1'b0;
                    if (!sel_hit) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else if (!req_wen_i[gnt]) begin
                        state_d = StRd;
                    end else if (sel_strb == '0) begin
                        state_d = StResp;
                    end else if (&sel_strb) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                clint_ren_o   = 1'b1;
                clint_raddr_o = 64'(addr_q);
                data_d        = clint_rdata_i;
                state_d       = wen_q ? StWr : StResp;
            end
            StWr: begin
                // data_q holds the RD sample for partial stores and zero for full ones.
                clint_wen_o   = 1'b1;
                clint_waddr_o = 64'(addr_q);
                clint_wdata_o = merged;
                data_d        = '0;
                state_d       = StResp;
            end
            StResp: begin
                rsp_valid_o[gnt_q] = 1'b1;
                rsp_rdata_o        = data_q;
                rsp_err_o          = err_q;
                if (rsp_ready_i[gnt_q]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            gnt_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

endmodule
